// File: rtl/rf_par_pkg.sv
// Shared types and widths for the RF-board parallel frequency-code receiver.
package rf_par_pkg;

    localparam int FREQ_W = 16;
    localparam int WIN_W  = 8;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_WAIT_LOW = 2'd3
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Generic multi-flop synchroniser; each bit passes through STG flops independently.
module sync_ff #(
    parameter int W   = 1,
    parameter int STG = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stg_q [STG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STG; i++) stg_q[i] <= '0;
        end else begin
            stg_q[0] <= d;
            for (int i = 1; i < STG; i++) stg_q[i] <= stg_q[i-1];
        end
    end

    assign q = stg_q[STG-1];

endmodule

// File: rtl/rf_parallel_rx.sv
// Receiver for the 16-bit parallel frequency-code link: synchronise, settle, confirm
// stability, range-check, then hand the code to the synthesiser loader.
//
// state    | meaning
// IDLE     | waiting for a synced ctrl rise
// SETTLE   | ignoring the bus while it settles after the rise
// CAPTURE  | counting consecutive identical bus samples
// WAIT_LOW | window finished (accept, range error or timeout); waiting for ctrl low
module rf_parallel_rx
    import rf_par_pkg::*;
#(
    parameter int                SYNC_STG   = 2,
    parameter int                SETTLE_CYC = 8,
    parameter int                STABLE_CYC = 4,
    parameter int                MAX_WIN    = 255,
    parameter logic [FREQ_W-1:0] FREQ_MAX   = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] i_rf_freq,
    input  logic              i_rf_freq_ctrl,
    output logic [FREQ_W-1:0] o_rf_freq,
    output logic              o_rf_freq_vld,
    output logic              o_busy,
    output logic              o_err_short,
    output logic              o_err_tmo,
    output logic              o_err_range,
    output logic [FREQ_W-1:0] o_frame_cnt
);

    logic [FREQ_W:0]   sync_q;
    logic              ctrl_s;
    logic [FREQ_W-1:0] bus_s;
    logic              ctrl_d;
    logic [SYNC_STG-1:0] prime_q;
    logic              primed;
    logic              armed_q;
    logic              ctrl_rise;
    logic              tmo_hit;
    logic              in_range;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  settle_q, settle_d;
    logic [CNT_W-1:0]  stable_q, stable_d, stable_nx;
    logic [WIN_W-1:0]  win_q;
    logic [FREQ_W-1:0] sample_q, sample_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [FREQ_W-1:0] frame_q, frame_d;
    logic              err_seen_q, err_seen_d;
    logic              vld_d, short_d, tmo_d, range_d;
    logic              vld_q, short_q, tmo_q, range_q;

    sync_ff #(.W(FREQ_W + 1), .STG(SYNC_STG)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({i_rf_freq_ctrl, i_rf_freq}),
        .q   (sync_q)
    );

    assign {ctrl_s, bus_s} = sync_q;

    // The synchroniser reads 0 while refilling after reset, so a rise is only trusted
    // once ctrl has been seen low with the pipeline full.
    assign primed    = prime_q[SYNC_STG-1];
    assign ctrl_rise = armed_q & ctrl_s & ~ctrl_d;
    assign tmo_hit   = ctrl_s && (win_q == WIN_W'(MAX_WIN - 1));
    assign in_range  = ({1'b0, bus_s} <= {1'b0, FREQ_MAX});

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_d     <= 1'b0;
            prime_q    <= '0;
            armed_q    <= 1'b0;
            state_q    <= ST_IDLE;
            settle_q   <= '0;
            stable_q   <= '0;
            win_q      <= '0;
            sample_q   <= '0;
            freq_q     <= '0;
            frame_q    <= '0;
            err_seen_q <= 1'b0;
            vld_q      <= 1'b0;
            short_q    <= 1'b0;
            tmo_q      <= 1'b0;
            range_q    <= 1'b0;
        end else begin
            ctrl_d     <= ctrl_s;
            prime_q    <= {prime_q[SYNC_STG-2:0], 1'b1};
            armed_q    <= armed_q | (primed & ~ctrl_s);
            state_q    <= state_d;
            settle_q   <= settle_d;
            stable_q   <= stable_d;
            sample_q   <= sample_d;
            freq_q     <= freq_d;
            frame_q    <= frame_d;
            err_seen_q <= err_seen_d;
            vld_q      <= vld_d;
            short_q    <= short_d;
            tmo_q      <= tmo_d;
            range_q    <= range_d;
            if (state_q == ST_IDLE)
                win_q <= '0;
            else if (ctrl_s && (win_q != WIN_W'(MAX_WIN)))
                win_q <= win_q + 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        stable_d   = stable_q;
        stable_nx  = stable_q;
        sample_d   = sample_q;
        freq_d     = freq_q;
        frame_d    = frame_q;
        err_seen_d = err_seen_q;
        vld_d      = 1'b0;
        short_d    = 1'b0;
        tmo_d      = 1'b0;
        range_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ctrl_rise) begin
                    state_d    = ST_SETTLE;
                    settle_d   = '0;
                    err_seen_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (!ctrl_s) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    tmo_d      = 1'b1;
                    err_seen_d = 1'b1;
                    state_d    = ST_WAIT_LOW;
                end else if (settle_q == CNT_W'(SETTLE_CYC - 1)) begin
                    state_d  = ST_CAPTURE;
                    sample_d = bus_s;
                    stable_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (!ctrl_s) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end else if (tmo_hit) begin
                    tmo_d      = 1'b1;
                    err_seen_d = 1'b1;
                    state_d    = ST_WAIT_LOW;
                end else begin
                    if (bus_s == sample_q) begin
                        stable_nx = stable_q + 1'b1;
                    end else begin
                        sample_d  = bus_s;
                        stable_nx = CNT_W'(1);
                    end
                    stable_d = stable_nx;
                    if (stable_nx == CNT_W'(STABLE_CYC)) begin
                        state_d = ST_WAIT_LOW;
                        if (in_range) begin
                            freq_d  = bus_s;
                            vld_d   = 1'b1;
                            frame_d = frame_q + 16'd1;
                        end else begin
                            range_d    = 1'b1;
                            err_seen_d = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_LOW: begin
                if (!ctrl_s) begin
                    state_d = ST_IDLE;
                end else if (tmo_hit && !err_seen_q) begin
                    tmo_d      = 1'b1;
                    err_seen_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_rf_freq     = freq_q;
    assign o_rf_freq_vld = vld_q;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_err_short   = short_q;
    assign o_err_tmo     = tmo_q;
    assign o_err_range   = range_q;
    assign o_frame_cnt   = frame_q;

endmodule
